// File: rtl/mem_stage.sv
// Memory stage of the lapido pipeline: data memory access, branch resolution
// and the MEM/WB register that produces the final write-back data.
module mem_stage #(
  parameter int GPR_WIDTH = 32,
  parameter int PC_WIDTH  = 32,
  parameter int DMEM_AW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_write_enable,
  input  logic                 sel_beq_bne,
  input  logic                 sel_jt_jf,
  input  logic                 is_branch,
  input  logic                 sel_jflag_branch,
  input  logic [1:0]           wb_res_mux,
  input  logic                 reg_write_enable,
  input  logic [4:0]           reg_dest,
  input  logic [GPR_WIDTH-1:0] imm,
  input  logic [PC_WIDTH-1:0]  next_pc,
  input  logic [PC_WIDTH-1:0]  branch_addr_in,
  input  logic [GPR_WIDTH-1:0] alu_res,
  input  logic [GPR_WIDTH-1:0] mem_addr,
  input  logic [GPR_WIDTH-1:0] mem_data,
  input  logic [5:0]           flags,
  output logic                 branch_taken,
  output logic [PC_WIDTH-1:0]  branch_addr,
  output logic [GPR_WIDTH-1:0] EX_MEM_data,
  output logic                 out_reg_write_enable,
  output logic [4:0]           out_reg_dest,
  output logic [GPR_WIDTH-1:0] MEM_WB_data
);

  localparam int DEPTH = 2 ** DMEM_AW;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_IMM  = 2'b10;
  localparam logic [1:0] WB_PC   = 2'b11;

  logic [GPR_WIDTH-1:0] dmem [DEPTH];
  logic [DMEM_AW-1:0]   addr;
  logic [GPR_WIDTH-1:0] ram_q;
  logic [GPR_WIDTH-1:0] res_q;
  logic [GPR_WIDTH-1:0] res_d;
  logic [1:0]           sel_q;
  logic [4:0]           dest_q;
  logic                 we_q;
  logic [7:0]           flags_ext;
  logic                 flag_bit;
  logic                 cond;

  assign addr = mem_addr[DMEM_AW-1:0];

  // Flag indices 6 and 7 land on the zero padding, so they read as 0.
  assign flags_ext = {2'b00, flags};
  assign flag_bit  = flags_ext[imm[2:0]];

  always_comb begin
    cond = 1'b0;
    if (sel_jflag_branch) cond = flag_bit ^ sel_jt_jf;
    else                  cond = flags[0] ^ sel_beq_bne;
  end

  assign branch_taken = is_branch & cond & ~rst;
  assign branch_addr  = branch_addr_in;
  assign EX_MEM_data  = alu_res;

  // Memory contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (mem_write_enable && !rst) dmem[addr] <= mem_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_q <= '0;
    else     ram_q <= dmem[addr];
  end

  always_comb begin
    res_d = '0;
    case (wb_res_mux)
      WB_ALU:  res_d = alu_res;
      WB_IMM:  res_d = imm;
      WB_PC:   res_d = GPR_WIDTH'(next_pc);
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      dest_q <= '0;
      sel_q  <= '0;
      res_q  <= '0;
    end else begin
      we_q   <= reg_write_enable & (reg_dest != 5'd0);
      dest_q <= reg_dest;
      sel_q  <= wb_res_mux;
      res_q  <= res_d;
    end
  end

  assign out_reg_write_enable = we_q;
  assign out_reg_dest         = dest_q;
  assign MEM_WB_data          = (sel_q == WB_LOAD) ? ram_q : res_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic
// compared against an array-based reference of the stage's behaviour.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write_enable, sel_beq_bne, sel_jt_jf, is_branch, sel_jflag_branch;
  logic [1:0]  wb_res_mux;
  logic        reg_write_enable;
  logic [4:0]  reg_dest;
  logic [31:0] imm, next_pc, branch_addr_in, alu_res, mem_addr, mem_data;
  logic [5:0]  flags;
  logic        branch_taken, out_reg_write_enable;
  logic [31:0] branch_addr, EX_MEM_data, MEM_WB_data;
  logic [4:0]  out_reg_dest;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] exp_wb;
  logic        exp_we;
  logic [4:0]  exp_dest;

  mem_stage #(.GPR_WIDTH(32), .PC_WIDTH(32), .DMEM_AW(8)) dut (
    .clk(clk), .rst(rst),
    .mem_write_enable(mem_write_enable), .sel_beq_bne(sel_beq_bne),
    .sel_jt_jf(sel_jt_jf), .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
    .wb_res_mux(wb_res_mux), .reg_write_enable(reg_write_enable), .reg_dest(reg_dest),
    .imm(imm), .next_pc(next_pc), .branch_addr_in(branch_addr_in), .alu_res(alu_res),
    .mem_addr(mem_addr), .mem_data(mem_data), .flags(flags),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .EX_MEM_data(EX_MEM_data),
    .out_reg_write_enable(out_reg_write_enable), .out_reg_dest(out_reg_dest),
    .MEM_WB_data(MEM_WB_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_branch();
    logic f;
    if (rst || !is_branch) return 1'b0;
    if (!sel_jflag_branch) return flags[0] ^ sel_beq_bne;
    f = (imm[2:0] > 3'd5) ? 1'b0 : flags[imm[2:0]];
    return f ^ sel_jt_jf;
  endfunction

  task automatic clear_inputs();
    mem_write_enable = 0; sel_beq_bne = 0; sel_jt_jf = 0; is_branch = 0;
    sel_jflag_branch = 0; wb_res_mux = 2'b00; reg_write_enable = 0; reg_dest = 0;
    imm = 0; next_pc = 0; branch_addr_in = 0; alu_res = 0; mem_addr = 0;
    mem_data = 0; flags = 0;
  endtask

  // Inputs are applied just after a falling edge; one call spans one MEM cycle.
  task automatic cycle();
    #1;
    check("branch_taken", {31'b0, branch_taken}, {31'b0, ref_branch()});
    check("branch_addr", branch_addr, branch_addr_in);
    check("ex_mem_data", EX_MEM_data, alu_res);
    @(posedge clk);
    if (rst) begin
      exp_we = 0; exp_dest = 0; exp_wb = 0;
    end else begin
      exp_we   = reg_write_enable && (reg_dest != 0);
      exp_dest = reg_dest;
      case (wb_res_mux)
        2'b00: exp_wb = alu_res;
        2'b01: exp_wb = ref_mem[mem_addr % 256];
        2'b10: exp_wb = imm;
        default: exp_wb = next_pc;
      endcase
      if (mem_write_enable) ref_mem[mem_addr % 256] = mem_data;
    end
    @(negedge clk);
    check("out_we", {31'b0, out_reg_write_enable}, {31'b0, exp_we});
    check("out_dest", {27'b0, out_reg_dest}, {27'b0, exp_dest});
    check("mem_wb_data", MEM_WB_data, exp_wb);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    clear_inputs();
    mem_write_enable = 1; mem_addr = a; mem_data = d;
    cycle();
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] rd);
    clear_inputs();
    wb_res_mux = 2'b01; mem_addr = a; reg_dest = rd; reg_write_enable = 1;
    cycle();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_we", {31'b0, out_reg_write_enable}, 32'd0);
    check("reset_dest", {27'b0, out_reg_dest}, 32'd0);
    check("reset_wb", MEM_WB_data, 32'd0);
    rst = 0;

    for (int i = 0; i < 256; i++) store(i, $urandom);

    store(32'd5, 32'hDEADBEEF);
    load(32'd5, 5'd3);
    check("load_deadbeef", MEM_WB_data, 32'hDEADBEEF);
    check("load_dest", {27'b0, out_reg_dest}, 32'd3);
    check("load_we", {31'b0, out_reg_write_enable}, 32'd1);

    store(32'h105, 32'h1234);
    load(32'd5, 5'd4);
    check("addr_wrap", MEM_WB_data, 32'h1234);

    clear_inputs();
    is_branch = 1; flags = 6'b000001; branch_addr_in = 32'h40;
    #1;
    check("beq_taken", {31'b0, branch_taken}, 32'd1);
    check("beq_addr", branch_addr, 32'h40);
    sel_beq_bne = 1;
    #1;
    check("bne_not_taken", {31'b0, branch_taken}, 32'd0);
    cycle();

    clear_inputs();
    is_branch = 1; sel_jflag_branch = 1; flags = 6'b100000; imm = 32'd5;
    #1;
    check("jt_flag5", {31'b0, branch_taken}, 32'd1);
    imm = 32'd6;
    #1;
    check("jt_flag6", {31'b0, branch_taken}, 32'd0);
    sel_jt_jf = 1;
    #1;
    check("jf_flag6", {31'b0, branch_taken}, 32'd1);
    cycle();

    clear_inputs();
    wb_res_mux = 2'b10; imm = 32'd7; reg_write_enable = 1; reg_dest = 5'd9;
    cycle();
    check("wb_imm", MEM_WB_data, 32'd7);
    clear_inputs();
    wb_res_mux = 2'b11; next_pc = 32'h21; reg_write_enable = 1; reg_dest = 5'd0;
    cycle();
    check("wb_next_pc", MEM_WB_data, 32'h21);
    check("r0_suppress", {31'b0, out_reg_write_enable}, 32'd0);

    // Reset asserted mid-store: outputs clear at once and the store is dropped.
    clear_inputs();
    alu_res = 32'h55; reg_write_enable = 1; reg_dest = 5'd7;
    cycle();
    clear_inputs();
    rst = 1; mem_write_enable = 1; mem_addr = 32'd5; mem_data = 32'hBAD0BAD0;
    is_branch = 1; flags = 6'b000001;
    #1;
    check("rst_async_we", {31'b0, out_reg_write_enable}, 32'd0);
    check("rst_async_dest", {27'b0, out_reg_dest}, 32'd0);
    check("rst_async_wb", MEM_WB_data, 32'd0);
    check("rst_branch", {31'b0, branch_taken}, 32'd0);
    cycle();
    rst = 0;
    load(32'd5, 5'd2);
    check("rst_no_write", MEM_WB_data, 32'h1234);

    for (int i = 0; i < 1500; i++) begin
      clear_inputs();
      mem_write_enable = 1'($urandom);
      sel_beq_bne      = 1'($urandom);
      sel_jt_jf        = 1'($urandom);
      is_branch        = 1'($urandom);
      sel_jflag_branch = 1'($urandom);
      wb_res_mux       = 2'($urandom);
      reg_write_enable = 1'($urandom);
      reg_dest         = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      imm              = $urandom;
      next_pc          = $urandom;
      branch_addr_in   = $urandom;
      alu_res          = $urandom;
      mem_addr         = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      mem_data         = $urandom;
      flags            = 6'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the lapido five-stage pipeline, between EX_stage and the register file write-back path. It takes the EX/MEM control and data bundle, accesses a word-addressed synchronous data memory, and resolves pc-relative and flag branches back to IF_stage and ID_stage. It registers the MEM/WB bundle and produces the final write-back data. The result also feeds fowarding_unit and EX_stage as `MEM_WB_data`.

## Interface
- GPR_WIDTH, 32, data and register width
- PC_WIDTH, 32, program counter width
- DMEM_AW, 8, data memory address bits (depth 2**DMEM_AW words)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; one clock, reset asynchronous and active-high
- mem_write_enable  input  1  store enable
- sel_beq_bne  input  1  0 = beq, 1 = bne
- sel_jt_jf  input  1  0 = jt, 1 = jf
- is_branch  input  1  instruction is a pc-relative branch
- sel_jflag_branch  input  1  0 = beq/bne condition, 1 = jt/jf condition
- wb_res_mux  input  2  write-back source: 00 alu_res, 01 load data, 10 imm, 11 next_pc
- reg_write_enable  input  1  register write request
- reg_dest  input  5  destination register
- imm  input  GPR_WIDTH  immediate; imm[2:0] selects the flag for jt/jf
- next_pc  input  PC_WIDTH  pc+1 of the instruction
- branch_addr_in  input  PC_WIDTH  computed branch target
- alu_res  input  GPR_WIDTH  ALU result
- mem_addr  input  GPR_WIDTH  data memory word address
- mem_data  input  GPR_WIDTH  store data
- flags  input  6  flags from EX; flags[0] = zero
- branch_taken  output  1  combinational, to IF_stage, ID_stage and EX_stage
- branch_addr  output  PC_WIDTH  combinational, equals branch_addr_in
- EX_MEM_data  output  GPR_WIDTH  combinational, equals alu_res; EX/MEM forwarding path
- out_reg_write_enable  output  1  registered write enable to the register file
- out_reg_dest  output  5  registered destination register
- MEM_WB_data  output  GPR_WIDTH  final write-back data; MEM/WB forwarding path

## Operation
- **Branch condition**
  - sel_jflag_branch = 0: cond = flags[0] XOR sel_beq_bne.
  - sel_jflag_branch = 1: f = flags[imm[2:0]], with f = 0 when imm[2:0] > 5; cond = f XOR sel_jt_jf.
  - branch_taken = is_branch AND cond. It is never asserted while rst = 1.
- **Data memory**
  - Array of 2**DMEM_AW words, indexed by mem_addr[DMEM_AW-1:0]. Upper address bits are ignored, so addresses wrap.
  - Write: when mem_write_enable = 1 at a clock edge, mem_data is written.
  - Read: synchronous, every cycle. The read register captures the word at the same address on the same edge, with the old contents (read-before-write).
  - Memory contents are not cleared by reset.
- **MEM/WB pipeline register**, loaded every cycle (this stage never stalls):
  - we_q = reg_write_enable AND (reg_dest != 0)
  - dest_q = reg_dest
  - sel_q = wb_res_mux
  - res_q = alu_res, imm or zero-extended next_pc, selected by wb_res_mux. For sel 01, res_q is don't-care and is cleared to 0.
- **Write-back data**: MEM_WB_data = ram_q when sel_q = 01, otherwise res_q.
- **Outputs**: out_reg_write_enable = we_q; out_reg_dest = dest_q.
- **Branch instruction itself**: completes normally in this stage; the flush of younger stages is the upstream stages' responsibility.
- **Reset** (asynchronous): we_q, dest_q, sel_q, res_q and ram_q all go to 0, so out_reg_write_enable = 0, out_reg_dest = 0, MEM_WB_data = 0. Reset mid-store: a write is not performed at any edge where rst = 1.

## Timing
- branch_taken, branch_addr and EX_MEM_data are combinational in the MEM cycle; there is no register in the path.
- Store: memory is updated at the end of the MEM cycle.
- Load: data is visible on MEM_WB_data one cycle after the MEM cycle, in the WB cycle. Total load latency from the MEM entry edge is 1 clock.
- Store to address A followed immediately by a load from A returns the new data, because the write edge precedes the read edge.
- Non-load results appear on MEM_WB_data one cycle after MEM.
- Deasserting rst takes effect at the next rising edge.

## Test plan
- **Reset**: assert rst mid-run with mem_write_enable = 1 -> outputs are 0 immediately, no write to the memory.
- **Store then load**: store 0xDEADBEEF to addr 5, then load addr 5 with wb_res_mux = 01, reg_dest = 3 -> next cycle MEM_WB_data = 0xDEADBEEF, out_reg_dest = 3, out_reg_write_enable = 1.
- **Address wrap**: store 0x1234 to addr 0x105 (DMEM_AW = 8), load addr 5 -> 0x1234.
- **beq/bne**: is_branch = 1, flags = 6'b000001, branch_addr_in = 0x40:
  - sel_beq_bne = 0 -> branch_taken = 1, branch_addr = 0x40.
  - sel_beq_bne = 1 -> branch_taken = 0.
- **jt/jf**: sel_jflag_branch = 1, flags = 6'b100000:
  - imm[2:0] = 5, jt -> taken.
  - imm[2:0] = 6 -> not taken for jt, taken for jf.
- **Write-back sources and r0 suppression**:
  - wb_res_mux = 10, imm = 7 -> MEM_WB_data = 7.
  - wb_res_mux = 11, next_pc = 0x21 -> MEM_WB_data = 0x21.
  - reg_write_enable = 1, reg_dest = 0 -> out_reg_write_enable = 0.
